page_table_responder: RTL and testbench

//  - Memory-side responder for the TLB miss path: serves the 8B-page and 32B-page table lookups.
//  - Stores one 8B table (64 entries, 6-bit PPN) and one 32B table (16 entries, 4-bit PPN).
//  - The tables are programmed through a write port.
//  - Walks are served one at a time after a fixed access latency, using a four-phase RQST/COMPLETE handshake per channel.

---
 rtl/page_table_responder_if.sv | 54 +++++
 rtl/page_table_responder.sv | 170 +++++++++++++++++
 tb/tb_page_table_responder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/page_table_responder_if.sv
// Walk request/response channels (8B and 32B pages) plus the page-table write port.
// Optional PAGE_8B_FAULT/PAGE_32B_FAULT signals exist only when PAGE_TABLE_FAULT_EN is defined.
interface page_table_responder_if;
    logic        PAGE_8B_RQST;
    logic [5:0]  PAGE_8B_LOOKUP;
    logic [11:0] PAGE_8B_RECV;
    logic        PAGE_8B_COMPLETE;

    logic        PAGE_32B_RQST;
    logic [3:0]  PAGE_32B_LOOKUP;
    logic [7:0]  PAGE_32B_RECV;
    logic        PAGE_32B_COMPLETE;

    logic        PT_WR_EN;
    logic        PT_WR_SEL;
    logic [5:0]  PT_WR_IDX;
    logic [5:0]  PT_WR_PPN;
    logic        PT_WR_VALID;

    logic        BUSY;

`ifdef PAGE_TABLE_FAULT_EN
    logic        PAGE_8B_FAULT;
    logic        PAGE_32B_FAULT;

    modport master (
        output PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
               PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
        input  PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
               BUSY, PAGE_8B_FAULT, PAGE_32B_FAULT
    );

    modport slave (
        input  PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
               PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
        output PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
               BUSY, PAGE_8B_FAULT, PAGE_32B_FAULT
    );
`else
    modport master (
        output PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
               PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
        input  PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
               BUSY
    );

    modport slave (
        input  PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
               PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
        output PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE,
               BUSY
    );
`endif
endinterface

// File: rtl/page_table_responder.sv
// Page-table responder for TLB misses: one walk at a time, COMPLETE ACCESS_LAT edges after grant.
// Latency ACCESS_LAT (1..15); requesters hold RQST until COMPLETE, the loser of arbitration simply waits.
// Optional entry valid bits / FAULT outputs under PAGE_TABLE_FAULT_EN.
module page_table_responder #(
    parameter int unsigned ACCESS_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    page_table_responder_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        gnt_ch;      // 0 = 8B channel, 1 = 32B channel
    logic        rr_ptr;      // channel preferred on the next contested grant
    logic [5:0]  idx;

    logic [5:0]  tbl8  [64];
    logic [3:0]  tbl32 [16];

    logic [11:0] recv8_q;
    logic [7:0]  recv32_q;
    logic        comp8_q;
    logic        comp32_q;

    logic        any_rqst;
    logic        pick;
    logic        gnt_rqst;
    logic [5:0]  rd_ppn8;
    logic [3:0]  rd_ppn32;
    logic        rd_ok;

    assign any_rqst = bus.PAGE_8B_RQST | bus.PAGE_32B_RQST;
    assign pick     = (bus.PAGE_8B_RQST && bus.PAGE_32B_RQST) ? rr_ptr : bus.PAGE_32B_RQST;
    assign gnt_rqst = gnt_ch ? bus.PAGE_32B_RQST : bus.PAGE_8B_RQST;

`ifdef PAGE_TABLE_FAULT_EN
    logic [63:0] vld8;
    logic [15:0] vld32;
    logic        flt8_q;
    logic        flt32_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld8  <= '0;
            vld32 <= '0;
        end else if (bus.PT_WR_EN) begin
            if (bus.PT_WR_SEL) begin
                vld32[bus.PT_WR_IDX[3:0]] <= bus.PT_WR_VALID;
            end else begin
                vld8[bus.PT_WR_IDX] <= bus.PT_WR_VALID;
            end
        end
    end

    assign rd_ok              = gnt_ch ? vld32[idx[3:0]] : vld8[idx];
    assign bus.PAGE_8B_FAULT  = flt8_q;
    assign bus.PAGE_32B_FAULT = flt32_q;
`else
    logic unused_wr_valid;

    assign unused_wr_valid = bus.PT_WR_VALID;
    assign rd_ok           = 1'b1;
`endif

    // Table storage; reads below see the pre-write contents on a shared edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                tbl8[i] <= 6'(i);
            end
            for (int j = 0; j < 16; j++) begin
                tbl32[j] <= 4'(j);
            end
        end else if (bus.PT_WR_EN) begin
            if (bus.PT_WR_SEL) begin
                tbl32[bus.PT_WR_IDX[3:0]] <= bus.PT_WR_PPN[3:0];
            end else begin
                tbl8[bus.PT_WR_IDX] <= bus.PT_WR_PPN;
            end
        end
    end

    always_comb begin
        rd_ppn8  = tbl8[idx];
        rd_ppn32 = tbl32[idx[3:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            gnt_ch   <= 1'b0;
            rr_ptr   <= 1'b0;
            idx      <= '0;
            recv8_q  <= '0;
            recv32_q <= '0;
            comp8_q  <= 1'b0;
            comp32_q <= 1'b0;
`ifdef PAGE_TABLE_FAULT_EN
            flt8_q   <= 1'b0;
            flt32_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_rqst) begin
                        gnt_ch <= pick;
                        rr_ptr <= ~pick;
                        idx    <= pick ? {2'b00, bus.PAGE_32B_LOOKUP} : bus.PAGE_8B_LOOKUP;
                        cnt    <= CNT_INIT;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!gnt_rqst) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        // An invalid entry still completes, but with a zero PPN.
                        if (gnt_ch) begin
                            recv32_q <= {idx[3:0], rd_ok ? rd_ppn32 : 4'h0};
                            comp32_q <= 1'b1;
`ifdef PAGE_TABLE_FAULT_EN
                            flt32_q  <= ~rd_ok;
`endif
                        end else begin
                            recv8_q  <= {idx, rd_ok ? rd_ppn8 : 6'h00};
                            comp8_q  <= 1'b1;
`ifdef PAGE_TABLE_FAULT_EN
                            flt8_q   <= ~rd_ok;
`endif
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!gnt_rqst) begin
                        recv8_q  <= '0;
                        recv32_q <= '0;
                        comp8_q  <= 1'b0;
                        comp32_q <= 1'b0;
`ifdef PAGE_TABLE_FAULT_EN
                        flt8_q   <= 1'b0;
                        flt32_q  <= 1'b0;
`endif
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PAGE_8B_RECV      = recv8_q;
    assign bus.PAGE_8B_COMPLETE  = comp8_q;
    assign bus.PAGE_32B_RECV     = recv32_q;
    assign bus.PAGE_32B_COMPLETE = comp32_q;
    assign bus.BUSY              = (state != ST_IDLE);

endmodule

// File: tb/tb_page_table_responder.sv
// Directed + randomized bench for page_table_responder against a table/arbitration reference model.
module tb_page_table_responder;

    localparam int LAT = 4;

    logic clk;
    logic rst_n;

    page_table_responder_if bus();

    page_table_responder #(.ACCESS_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays holding what each table entry should contain.
    logic [5:0] m8  [64];
    logic [3:0] m32 [16];
    bit         v8  [64];
    bit         v32 [16];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit model_vld(input bit wv);
`ifdef PAGE_TABLE_FAULT_EN
        return wv;
`else
        return 1'b1 | wv;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m8[i] = 6'(i);
            v8[i] = model_vld(1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            m32[j] = 4'(j);
            v32[j] = model_vld(1'b0);
        end
    endtask

    task automatic model_write(input bit sel, input logic [5:0] idx, input logic [5:0] ppn, input bit wv);
        if (sel) begin
            m32[idx[3:0]] = ppn[3:0];
            v32[idx[3:0]] = model_vld(wv);
        end else begin
            m8[idx] = ppn;
            v8[idx] = model_vld(wv);
        end
    endtask

    function automatic logic [11:0] pack(input bit ch, input logic [5:0] key, input logic [5:0] ppn, input bit v);
        if (ch) return {4'h0, key[3:0], (v ? ppn[3:0] : 4'h0)};
        return {key, (v ? ppn : 6'h00)};
    endfunction

    function automatic logic comp_of(input bit ch);
        return ch ? bus.PAGE_32B_COMPLETE : bus.PAGE_8B_COMPLETE;
    endfunction

    function automatic logic [11:0] recv_of(input bit ch);
        return ch ? {4'h0, bus.PAGE_32B_RECV} : bus.PAGE_8B_RECV;
    endfunction

    function automatic logic flt_of(input bit ch);
`ifdef PAGE_TABLE_FAULT_EN
        return ch ? bus.PAGE_32B_FAULT : bus.PAGE_8B_FAULT;
`else
        return 1'b0 & ch;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rqst(input bit ch, input bit val);
        if (ch) bus.PAGE_32B_RQST = val;
        else    bus.PAGE_8B_RQST  = val;
    endtask

    task automatic set_lookup(input bit ch, input logic [5:0] lk);
        if (ch) bus.PAGE_32B_LOOKUP = lk[3:0];
        else    bus.PAGE_8B_LOOKUP  = lk;
    endtask

    task automatic wr(input bit sel, input logic [5:0] idx, input logic [5:0] ppn, input bit wv);
        bus.PT_WR_EN    = 1'b1;
        bus.PT_WR_SEL   = sel;
        bus.PT_WR_IDX   = idx;
        bus.PT_WR_PPN   = ppn;
        bus.PT_WR_VALID = wv;
        tick();
        bus.PT_WR_EN    = 1'b0;
        model_write(sel, idx, ppn, wv);
    endtask

    task automatic wait_comp(input bit ch, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (comp_of(ch)) begin
                lat = i;
                break;
            end
        end
    endtask

    // One complete walk: request, optional table write at offset wj after grant,
    // latency/data/hold checks, then release and check the clear.
    task automatic walk(input bit ch, input logic [5:0] lk, input bit wr_on, input bit wsel,
                        input logic [5:0] widx, input logic [5:0] wppn, input bit wv,
                        input int wj, output logic [11:0] got);
        logic [5:0]  key;
        logic [5:0]  ppn;
        bit          v;
        bit          hit;
        logic [11:0] exp_r;
        int          lat;
        key = ch ? {2'b00, lk[3:0]} : lk;
        ppn = ch ? {2'b00, m32[key[3:0]]} : m8[key];
        v   = ch ? v32[key[3:0]] : v8[key];
        hit = wr_on && (wsel == ch) && (ch ? (widx[3:0] == key[3:0]) : (widx == key));
        // A write only reaches the result if it lands strictly before the read edge.
        if (hit && (wj + 1 < LAT)) begin
            ppn = wppn;
            v   = model_vld(wv);
        end
        exp_r = pack(ch, key, ppn, v);
        got   = '0;
        lat   = -1;
        set_lookup(ch, lk);
        set_rqst(ch, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) begin
                chk("busy_after_grant", 16'(bus.BUSY), 16'd1);
                set_lookup(ch, 6'($urandom_range(0, 63)));
            end
            if (lat < 0) begin
                if (comp_of(ch)) begin
                    lat = i;
                    got = recv_of(ch);
                    chk("latency", 16'(lat), 16'(LAT));
                    chk("recv", 16'(got), 16'(exp_r));
                    chk("fault", 16'(flt_of(ch)), 16'(!v));
                    chk("other_comp_low", 16'(comp_of(!ch)), 16'd0);
                end
            end else begin
                chk("hold_comp", 16'(comp_of(ch)), 16'd1);
                chk("hold_recv", 16'(recv_of(ch)), 16'(exp_r));
            end
            if (wr_on && i == wj) begin
                bus.PT_WR_EN    = 1'b1;
                bus.PT_WR_SEL   = wsel;
                bus.PT_WR_IDX   = widx;
                bus.PT_WR_PPN   = wppn;
                bus.PT_WR_VALID = wv;
                model_write(wsel, widx, wppn, wv);
            end else begin
                bus.PT_WR_EN = 1'b0;
            end
            if (lat >= 0 && i >= lat + 2 && (!wr_on || i > wj)) break;
        end
        bus.PT_WR_EN = 1'b0;
        chk("walk_finished", 16'(lat >= 0), 16'd1);
        set_rqst(ch, 1'b0);
        tick();
        chk("comp_clear", 16'(comp_of(ch)), 16'd0);
        chk("recv_clear", 16'(recv_of(ch)), 16'd0);
        chk("busy_clear", 16'(bus.BUSY), 16'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.PAGE_8B_RQST    = 1'b0;
        bus.PAGE_32B_RQST   = 1'b0;
        bus.PAGE_8B_LOOKUP  = '0;
        bus.PAGE_32B_LOOKUP = '0;
        bus.PT_WR_EN        = 1'b0;
        bus.PT_WR_SEL       = 1'b0;
        bus.PT_WR_IDX       = '0;
        bus.PT_WR_PPN       = '0;
        bus.PT_WR_VALID     = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] got;
        int          lat;

        // Reset values
        do_reset();
        chk("rst_comp8",  16'(bus.PAGE_8B_COMPLETE),  16'd0);
        chk("rst_recv8",  16'(bus.PAGE_8B_RECV),      16'd0);
        chk("rst_comp32", 16'(bus.PAGE_32B_COMPLETE), 16'd0);
        chk("rst_recv32", 16'(bus.PAGE_32B_RECV),     16'd0);
        chk("rst_busy",   16'(bus.BUSY),              16'd0);

`ifdef PAGE_TABLE_FAULT_EN
        walk(1'b0, 6'h07, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 0, got);
        chk("fault_idx7_recv", 16'(got), 16'h01C0);
`endif

        // Identity map after reset
        walk(1'b0, 6'h2A, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 0, got);
`ifndef PAGE_TABLE_FAULT_EN
        chk("ident_2A", 16'(got), 16'h0AAA);
`endif

        // Programmed 32B entry
        wr(1'b1, 6'h05, 6'h0C, 1'b1);
        walk(1'b1, 6'h05, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 0, got);
        chk("wr32_5C", 16'(got), 16'h005C);

        // Contention: 8B first, 32B held off, then round robin favours 32B
        do_reset();
        set_lookup(1'b0, 6'h11);
        set_lookup(1'b1, 6'h07);
        set_rqst(1'b0, 1'b1);
        set_rqst(1'b1, 1'b1);
        wait_comp(1'b0, lat);
        chk("pair_8b_lat",  16'(lat), 16'(LAT));
        chk("pair_8b_recv", 16'(bus.PAGE_8B_RECV), 16'(pack(1'b0, 6'h11, m8[6'h11], v8[6'h11])));
        chk("pair_32b_low", 16'(bus.PAGE_32B_COMPLETE), 16'd0);
        tick();
        tick();
        chk("pair_32b_wait", 16'(bus.PAGE_32B_COMPLETE), 16'd0);
        set_rqst(1'b0, 1'b0);
        tick();
        chk("pair_8b_drop", 16'(bus.PAGE_8B_COMPLETE), 16'd0);
        set_rqst(1'b0, 1'b1);
        wait_comp(1'b1, lat);
        chk("rr_32b_lat",  16'(lat), 16'(LAT));
        chk("rr_32b_recv", 16'(bus.PAGE_32B_RECV), 16'(pack(1'b1, 6'h07, {2'b00, m32[4'h7]}, v32[4'h7])));
        chk("rr_8b_low",   16'(bus.PAGE_8B_COMPLETE), 16'd0);
        set_rqst(1'b1, 1'b0);
        tick();
        chk("rr_32b_drop", 16'(bus.PAGE_32B_COMPLETE), 16'd0);
        wait_comp(1'b0, lat);
        chk("pending_8b_lat", 16'(lat), 16'(LAT));
        set_rqst(1'b0, 1'b0);
        tick();
        chk("pending_8b_drop", 16'(bus.PAGE_8B_COMPLETE), 16'd0);

        // Abort during WAIT, then an immediate re-request
        set_lookup(1'b0, 6'h15);
        set_rqst(1'b0, 1'b1);
        tick();
        chk("abort_busy", 16'(bus.BUSY), 16'd1);
        tick();
        set_rqst(1'b0, 1'b0);
        tick();
        chk("abort_comp", 16'(bus.PAGE_8B_COMPLETE), 16'd0);
        chk("abort_idle", 16'(bus.BUSY), 16'd0);
        walk(1'b0, 6'h15, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 0, got);

        // Asynchronous reset mid-walk restores the identity map
        wr(1'b0, 6'h03, 6'h11, 1'b1);
        set_lookup(1'b0, 6'h03);
        set_rqst(1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  16'(bus.BUSY),             16'd0);
        chk("arst_comp8", 16'(bus.PAGE_8B_COMPLETE), 16'd0);
        chk("arst_recv8", 16'(bus.PAGE_8B_RECV),     16'd0);
        set_rqst(1'b0, 1'b0);
        model_reset();
        tick();
        rst_n = 1'b1;
        walk(1'b0, 6'h03, 1'b0, 1'b0, 6'h0, 6'h0, 1'b0, 0, got);
`ifndef PAGE_TABLE_FAULT_EN
        chk("arst_ident_3", 16'(got), 16'h00C3);
`endif

        // Randomized walks with writes landing before, on, and after the read edge
        for (int it = 0; it < 40; it++) begin
            bit         ch;
            logic [5:0] lk;
            bit         wr_on;
            bit         wsel;
            logic [5:0] widx;
            if ($urandom_range(0, 1) == 1)
                wr(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                   6'($urandom_range(0, 63)), 1'($urandom_range(0, 3) != 0));
            ch    = 1'($urandom_range(0, 1));
            lk    = 6'($urandom_range(0, 63));
            wr_on = 1'($urandom_range(0, 1));
            wsel  = ($urandom_range(0, 3) != 0) ? ch : !ch;
            widx  = ($urandom_range(0, 1) == 1) ? lk : 6'($urandom_range(0, 63));
            walk(ch, lk, wr_on, wsel, widx, 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, LAT + 1)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
